multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RISC-V core: it drives the ALU's `ALUctrl_i`/`BranchCtrl_i` and consumes the ALU's `Branch_o`. It sequences each instruction through fetch, decode, execute, memory and writeback. It asserts datapath mux selects and write enables per state and handshakes with instruction and data memory. It sits beside the ALU in the core top and replaces combinational single-cycle decode.

---
 rtl/multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback.
// Optional macro MULTICYCLE_RETIRE_CNT_EN adds the 32-bit InstrRetired_o counter.
module multicycle_ctrl #(
   parameter int unsigned DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATAWIDTH-1:0] Instr_i,
   input  logic                 InstrValid_i,
   input  logic                 MemReady_i,
   input  logic                 Branch_i,
   output logic                 InstrReq_o,
   output logic                 IRWrite_o,
   output logic                 PCWrite_o,
   output logic                 PCSrc_o,
   output logic [1:0]           ALUSrcA_o,
   output logic [1:0]           ALUSrcB_o,
   output logic [3:0]           ALUctrl_o,
   output logic [2:0]           BranchCtrl_o,
   output logic                 MemRead_o,
   output logic                 MemWrite_o,
   output logic                 RegWrite_o,
   output logic                 ResultSrc_o,
   output logic                 Trap_o
`ifdef MULTICYCLE_RETIRE_CNT_EN
   ,
   output logic [31:0]          InstrRetired_o
`endif
);

   localparam int unsigned OPW  = 7;
   localparam int unsigned ALUW = 4;
   localparam int unsigned SELW = 2;

   localparam logic [OPW-1:0] OP_R      = 7'b0110011;
   localparam logic [OPW-1:0] OP_I      = 7'b0010011;
   localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;

   localparam logic [ALUW-1:0] ALU_ADD   = 4'b0000;
   localparam logic [ALUW-1:0] ALU_SUB   = 4'b0001;
   localparam logic [ALUW-1:0] ALU_SLL   = 4'b0010;
   localparam logic [ALUW-1:0] ALU_SLT   = 4'b0011;
   localparam logic [ALUW-1:0] ALU_SLTU  = 4'b0100;
   localparam logic [ALUW-1:0] ALU_XOR   = 4'b0101;
   localparam logic [ALUW-1:0] ALU_SRL   = 4'b0110;
   localparam logic [ALUW-1:0] ALU_SRA   = 4'b0111;
   localparam logic [ALUW-1:0] ALU_OR    = 4'b1000;
   localparam logic [ALUW-1:0] ALU_AND   = 4'b1001;
   localparam logic [ALUW-1:0] ALU_PASSB = 4'b1010;

   localparam logic [SELW-1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
   localparam logic [SELW-1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
   } state_t;

   state_t          state_q, state_nxt;
   logic [OPW-1:0]  opc_q;
   logic [2:0]      f3_q;
   logic            f7b5_q;
   logic            br_en_q;
   logic [SELW-1:0] srcb_q;

   logic            fetch_hs, is_load, is_store, legal;
   logic [ALUW-1:0] alu_op;

   logic            req_d, pcsrc_d, br_en_d, mr_d, mw_d, rw_d, rs_d, trap_d;
   logic [SELW-1:0] srca_d, srcb_d;
   logic [ALUW-1:0] ctrl_d;
   logic [2:0]      bctrl_d;

   // Only opcode, funct3 and funct7[5] steer control; remaining fields belong to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{Instr_i[DATAWIDTH-1:31], Instr_i[29:15], Instr_i[11:7]};

   // The FETCH handshake needs the registered request so the post-reset cycle cannot fetch.
   assign fetch_hs  = InstrReq_o & InstrValid_i;
   assign IRWrite_o = fetch_hs;
   assign PCWrite_o = fetch_hs | (br_en_q & Branch_i);
   assign ALUSrcB_o = fetch_hs ? B_FOUR : srcb_q;

   assign is_load  = (opc_q == OP_LOAD);
   assign is_store = (opc_q == OP_STORE);
   assign legal    = (opc_q == OP_R) || (opc_q == OP_I) || is_load || is_store ||
                     (opc_q == OP_BRANCH) || (opc_q == OP_LUI);

   always_comb begin
      alu_op = ALU_ADD;
      case (f3_q)
         3'b000:  alu_op = ((opc_q == OP_R) && f7b5_q) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = f7b5_q ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_FETCH:     if (fetch_hs) state_nxt = S_DECODE;
         S_DECODE:    state_nxt = legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            if (is_load || is_store)     state_nxt = S_MEMORY;
            else if (opc_q == OP_BRANCH) state_nxt = S_FETCH;
            else                         state_nxt = S_WRITEBACK;
         end
         S_MEMORY:    if (MemReady_i) state_nxt = is_load ? S_WRITEBACK : S_FETCH;
         S_WRITEBACK: state_nxt = S_FETCH;
         S_TRAP:      state_nxt = S_TRAP;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // Moore outputs are decoded from the next state so they register in step with the state.
   always_comb begin
      req_d   = 1'b0;
      pcsrc_d = 1'b0;
      br_en_d = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      rw_d    = 1'b0;
      rs_d    = 1'b0;
      trap_d  = 1'b0;
      srca_d  = A_PC;
      srcb_d  = B_RS2;
      ctrl_d  = ALU_ADD;
      bctrl_d = 3'b000;
      case (state_nxt)
         S_FETCH:  req_d = 1'b1;
         S_DECODE: begin
            srca_d = A_OLDPC;
            srcb_d = B_IMM;
         end
         S_EXECUTE: begin
            if (opc_q == OP_R) begin
               srca_d = A_RS1;
               ctrl_d = alu_op;
            end else if (opc_q == OP_I) begin
               srca_d = A_RS1;
               srcb_d = B_IMM;
               ctrl_d = alu_op;
            end else if (opc_q == OP_LUI) begin
               srcb_d = B_IMM;
               ctrl_d = ALU_PASSB;
            end else if (opc_q == OP_BRANCH) begin
               srca_d  = A_RS1;
               ctrl_d  = ALU_SUB;
               bctrl_d = f3_q;
               pcsrc_d = 1'b1;
               br_en_d = 1'b1;
            end else begin
               srca_d = A_RS1;
               srcb_d = B_IMM;
            end
         end
         S_MEMORY: begin
            mr_d = is_load;
            mw_d = is_store;
         end
         S_WRITEBACK: begin
            rw_d = 1'b1;
            rs_d = is_load;
         end
         S_TRAP:  trap_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         opc_q        <= '0;
         f3_q         <= '0;
         f7b5_q       <= 1'b0;
         br_en_q      <= 1'b0;
         srcb_q       <= '0;
         InstrReq_o   <= 1'b0;
         PCSrc_o      <= 1'b0;
         ALUSrcA_o    <= '0;
         ALUctrl_o    <= '0;
         BranchCtrl_o <= '0;
         MemRead_o    <= 1'b0;
         MemWrite_o   <= 1'b0;
         RegWrite_o   <= 1'b0;
         ResultSrc_o  <= 1'b0;
         Trap_o       <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         if (fetch_hs) begin
            opc_q  <= Instr_i[6:0];
            f3_q   <= Instr_i[14:12];
            f7b5_q <= Instr_i[30];
         end
         br_en_q      <= br_en_d;
         srcb_q       <= srcb_d;
         InstrReq_o   <= req_d;
         PCSrc_o      <= pcsrc_d;
         ALUSrcA_o    <= srca_d;
         ALUctrl_o    <= ctrl_d;
         BranchCtrl_o <= bctrl_d;
         MemRead_o    <= mr_d;
         MemWrite_o   <= mw_d;
         RegWrite_o   <= rw_d;
         ResultSrc_o  <= rs_d;
         Trap_o       <= trap_d;
      end
   end

`ifdef MULTICYCLE_RETIRE_CNT_EN
   // An instruction retires when it leaves its final state.
   logic retire;
   assign retire = (state_q == S_WRITEBACK) ||
                   ((state_q == S_MEMORY) && MemReady_i && is_store) ||
                   ((state_q == S_EXECUTE) && (opc_q == OP_BRANCH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      InstrRetired_o <= '0;
      else if (retire) InstrRetired_o <= InstrRetired_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle-trace model, random stimulus.
// Define MULTICYCLE_RETIRE_CNT_EN to also check the retired-instruction counter.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       req, irw, pcw, pcsrc;
      logic [1:0] a, b;
      logic [3:0] ctrl;
      logic [2:0] bctrl;
      logic       mr, mw, rw, rs, trap;
   } outs_t;

   typedef enum {K_R, K_I, K_LUI, K_LD, K_ST, K_BR, K_ILL} kind_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0, mem_ready = 1'b0, branch = 1'b0;
   logic        instr_req, ir_write, pc_write, pc_src;
   logic [1:0]  alu_src_a, alu_src_b;
   logic [3:0]  alu_ctrl;
   logic [2:0]  branch_ctrl;
   logic        mem_read, mem_write, reg_write, result_src, trap;
`ifdef MULTICYCLE_RETIRE_CNT_EN
   logic [31:0] instr_retired;
   logic [31:0] retired = '0;
`endif

   int    n_checks = 0;
   int    n_pass = 0;
   outs_t exp_cur = '0;
   bit    exp_valid = 1'b0;
   string exp_tag = "";

   multicycle_ctrl #(.DATAWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .Instr_i(instr), .InstrValid_i(instr_valid),
      .MemReady_i(mem_ready), .Branch_i(branch), .InstrReq_o(instr_req),
      .IRWrite_o(ir_write), .PCWrite_o(pc_write), .PCSrc_o(pc_src),
      .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b), .ALUctrl_o(alu_ctrl),
      .BranchCtrl_o(branch_ctrl), .MemRead_o(mem_read), .MemWrite_o(mem_write),
      .RegWrite_o(reg_write), .ResultSrc_o(result_src), .Trap_o(trap)
`ifdef MULTICYCLE_RETIRE_CNT_EN
      , .InstrRetired_o(instr_retired)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   function automatic outs_t sample();
      outs_t s;
      s = {instr_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
           branch_ctrl, mem_read, mem_write, reg_write, result_src, trap};
      return s;
   endfunction

   // Outputs are checked mid-cycle against whatever the model expects for this cycle.
   always @(negedge clk) begin
      if (exp_valid) check({"cycle ", exp_tag}, 32'(sample()), 32'(exp_cur));
   end

   function automatic kind_t kind_of(input logic [31:0] ins);
      kind_t k;
      case (ins[6:0])
         7'b0110011: k = K_R;
         7'b0010011: k = K_I;
         7'b0110111: k = K_LUI;
         7'b0000011: k = K_LD;
         7'b0100011: k = K_ST;
         7'b1100011: k = K_BR;
         default:    k = K_ILL;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] alu_exp(input logic [31:0] ins);
      logic [3:0] tbl [8];
      logic [3:0] op;
      tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      op = tbl[ins[14:12]];
      if (ins[14:12] == 3'd0 && ins[30] && kind_of(ins) == K_R) op = 4'd1;
      if (ins[14:12] == 3'd5 && ins[30]) op = 4'd7;
      return op;
   endfunction

   function automatic outs_t e_fetch(input bit hs);
      outs_t e = '0;
      e.req = 1'b1;
      if (hs) begin
         e.irw = 1'b1;
         e.pcw = 1'b1;
         e.b   = 2'b10;
      end
      return e;
   endfunction

   function automatic outs_t e_decode();
      outs_t e = '0;
      e.a = 2'b01;
      e.b = 2'b01;
      return e;
   endfunction

   function automatic outs_t e_exec(input logic [31:0] ins, input logic br);
      outs_t e = '0;
      case (kind_of(ins))
         K_R:   begin e.a = 2'b10; e.ctrl = alu_exp(ins); end
         K_I:   begin e.a = 2'b10; e.b = 2'b01; e.ctrl = alu_exp(ins); end
         K_LUI: begin e.b = 2'b01; e.ctrl = 4'd10; end
         K_BR:  begin
            e.a = 2'b10; e.ctrl = 4'd1; e.bctrl = ins[14:12];
            e.pcsrc = 1'b1; e.pcw = br;
         end
         default: begin e.a = 2'b10; e.b = 2'b01; end
      endcase
      return e;
   endfunction

   function automatic outs_t e_mem(input kind_t k);
      outs_t e = '0;
      e.mr = (k == K_LD);
      e.mw = (k == K_ST);
      return e;
   endfunction

   function automatic outs_t e_wb(input kind_t k);
      outs_t e = '0;
      e.rw = 1'b1;
      e.rs = (k == K_LD);
      return e;
   endfunction

   function automatic outs_t e_trap();
      outs_t e = '0;
      e.trap = 1'b1;
      return e;
   endfunction

   task automatic step(input logic [31:0] ins, input logic iv, input logic mr, input logic br,
                       input outs_t e, input string tag);
      instr = ins; instr_valid = iv; mem_ready = mr; branch = br;
      exp_cur = e; exp_tag = tag; exp_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      exp_valid = 1'b0;
      instr_valid = 1'b1; mem_ready = 1'b1; branch = 1'b1;
      rst_n = 1'b0;
      #1 check("reset-async", 32'(sample()), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      check("reset-held", 32'(sample()), 32'd0);
      rst_n = 1'b1;
      #1 check("reset-release", 32'(sample()), 32'd0);
      instr_valid = 1'b0;
      @(posedge clk); #1;
`ifdef MULTICYCLE_RETIRE_CNT_EN
      retired = '0;
      check("retired-reset", instr_retired, retired);
`endif
   endtask

   // Expands one instruction into its expected cycle trace; returns its length in cycles.
   task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic br,
                            output int ncyc);
      kind_t k;
      k = kind_of(ins);
      ncyc = 0;
      for (int i = 0; i < wf; i++) begin
         step($urandom, 1'b0, 1'($urandom), 1'($urandom), e_fetch(1'b0), "fetch-wait");
         ncyc++;
      end
      step(ins, 1'b1, 1'($urandom), 1'($urandom), e_fetch(1'b1), "fetch");
      step($urandom, 1'($urandom), 1'($urandom), 1'($urandom), e_decode(), "decode");
      ncyc += 2;
      if (k == K_ILL) begin
         for (int i = 0; i < 3; i++) begin
            step($urandom, 1'b1, 1'($urandom), 1'($urandom), e_trap(), "trap");
            if (i == 0) ncyc++;
         end
         return;
      end
      step($urandom, 1'($urandom), 1'($urandom), br, e_exec(ins, br), "execute");
      ncyc++;
      if (k == K_LD || k == K_ST) begin
         for (int i = 0; i < wm; i++) begin
            step($urandom, 1'($urandom), 1'b0, 1'($urandom), e_mem(k), "mem-wait");
            ncyc++;
         end
         step($urandom, 1'($urandom), 1'b1, 1'($urandom), e_mem(k), "mem");
         ncyc++;
      end
      if (k != K_ST && k != K_BR) begin
         step($urandom, 1'($urandom), 1'($urandom), 1'($urandom), e_wb(k), "writeback");
         ncyc++;
      end
`ifdef MULTICYCLE_RETIRE_CNT_EN
      retired = retired + 32'd1;
      check("retired", instr_retired, retired);
`endif
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int sel;
      r = $urandom;
      sel = $urandom_range(0, 19);
      if (sel < 4)       r[6:0] = 7'b0110011;
      else if (sel < 8)  r[6:0] = 7'b0010011;
      else if (sel < 10) r[6:0] = 7'b0110111;
      else if (sel < 13) r[6:0] = 7'b0000011;
      else if (sel < 16) r[6:0] = 7'b0100011;
      else if (sel < 19) r[6:0] = 7'b1100011;
      else if (kind_of(r) != K_ILL) r[6:0] = 7'h7F;
      return r;
   endfunction

   initial begin
      int n;
      logic [31:0] ins;
      @(posedge clk); #1;
      do_reset();

      // Idle fetch: request held, nothing else moves.
      for (int i = 0; i < 3; i++)
         step($urandom, 1'b0, 1'($urandom), 1'($urandom), e_fetch(1'b0), "idle");

      check("pin-add-op", 32'(alu_exp(32'h002081B3)), 32'd0);
      check("pin-sub-op", 32'(alu_exp(32'h402081B3)), 32'd1);
      check("pin-srai-op", 32'(alu_exp(32'h4020D193)), 32'd7);
      check("pin-beq-bctrl", 32'(e_exec(32'h00208463, 1'b1).bctrl), 32'd0);

      run_instr(32'h002081B3, 0, 0, 1'b0, n); check("add-cycles", n, 4);
      run_instr(32'h402081B3, 0, 0, 1'b1, n); check("sub-cycles", n, 4);
      run_instr(32'h4020D193, 1, 0, 1'b1, n); check("srai-cycles", n, 5);
      run_instr(32'h0000A183, 0, 2, 1'b1, n); check("lw-cycles", n, 7);
      run_instr(32'h00208463, 0, 0, 1'b1, n); check("beq-taken-cycles", n, 3);
      run_instr(32'h00208463, 0, 0, 1'b0, n); check("beq-not-taken-cycles", n, 3);
      run_instr(32'h0020A023, 0, 0, 1'b0, n); check("sw-cycles", n, 4);
      run_instr(32'h123450B7, 0, 0, 1'b1, n); check("lui-cycles", n, 4);

      do_reset();
      run_instr(32'h002081B3, 0, 0, 1'b0, n);
      run_instr(32'h00208463, 0, 0, 1'b1, n);
      run_instr(32'h0020A023, 0, 1, 1'b0, n);
`ifdef MULTICYCLE_RETIRE_CNT_EN
      check("retired-three", instr_retired, 32'd3);
`endif

      // Reset landing mid-load must clear everything before any writeback.
      ins = 32'h0000A183;
      step(ins, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), "mid-fetch");
      step($urandom, 1'b0, 1'b0, 1'b0, e_decode(), "mid-decode");
      step($urandom, 1'b0, 1'b0, 1'b0, e_exec(ins, 1'b0), "mid-execute");
      step($urandom, 1'b0, 1'b0, 1'b0, e_mem(K_LD), "mid-mem");
      do_reset();

      run_instr(32'h0000007F, 0, 0, 1'b0, n); check("trap-entry-cycle", n, 3);
      do_reset();
      run_instr(32'h002081B3, 0, 0, 1'b0, n);

      for (int t = 0; t < 400; t++) begin
         ins = rand_instr();
         run_instr(ins, ($urandom % 2) ? 0 : $urandom_range(1, 3),
                   ($urandom % 2) ? 0 : $urandom_range(1, 3), 1'($urandom), n);
         if (kind_of(ins) == K_ILL) do_reset();
      end

      exp_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
